// File: rtl/pcm_pkg.sv
// Shared types and defaults for the PCM request scheduler.
package pcm_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 16;

  // Queue entries are stored at a fixed maximum width so one struct type
  // serves every legal ADDR_W/DATA_W (both must be <= these limits).
  localparam int unsigned WQ_ADDR_MAX_W = 32;
  localparam int unsigned WQ_DATA_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_BUSY,
    WR_BUSY
  } state_e;

  typedef struct packed {
    logic [WQ_ADDR_MAX_W-1:0] addr;
    logic [WQ_DATA_MAX_W-1:0] data;
    logic                     valid;
  } wq_entry_t;

endpackage

// File: rtl/pcm_wq.sv
// Write queue: circular FIFO with parallel address match for read
// forwarding and write coalescing; the in-flight head is masked from
// coalescing.
module pcm_wq
  import pcm_pkg::*;
#(
  parameter  int unsigned ADDR_W = ADDR_W_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              coal,
  input  logic [PTR_W-1:0]  coal_idx,
  input  logic              pop,
  input  logic              head_busy,
  input  logic [ADDR_W-1:0] match_addr,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_hit,
  output logic [PTR_W-1:0]  wr_idx
);

  wq_entry_t        mem_q [DEPTH];
  wq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] tail;
  logic [DEPTH-1:0] busy_mask;
  int unsigned      p;

  function automatic logic [PTR_W-1:0] wrap(input int unsigned v);
    return PTR_W'(v % DEPTH);
  endfunction

  // Parallel match walking oldest to youngest so the youngest hit wins.
  always_comb begin
    rd_hit    = 1'b0;
    rd_data   = '0;
    wr_hit    = 1'b0;
    wr_idx    = '0;
    busy_mask = '0;
    p         = 0;
    if (head_busy) busy_mask[head_q] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      p = (32'(head_q) + i) % DEPTH;
      if (mem_q[PTR_W'(p)].valid &&
          mem_q[PTR_W'(p)].addr == WQ_ADDR_MAX_W'(match_addr)) begin
        rd_hit  = 1'b1;
        rd_data = DATA_W'(mem_q[PTR_W'(p)].data);
        if (!busy_mask[PTR_W'(p)]) begin
          wr_hit = 1'b1;
          wr_idx = PTR_W'(p);
        end
      end
    end
  end

  // Head view; a coalesce into the head on the issue cycle is forwarded so
  // the issued command carries the newest data.
  always_comb begin
    count     = count_q;
    head_addr = ADDR_W'(mem_q[head_q].addr);
    head_data = (coal && coal_idx == head_q) ? push_data
                                             : DATA_W'(mem_q[head_q].data);
  end

  // Next queue contents: coalesce, pop head, push tail.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail    = wrap(32'(head_q) + 32'(count_q));
    if (coal) mem_d[coal_idx].data = WQ_DATA_MAX_W'(push_data);
    if (pop) begin
      mem_d[head_q].valid = 1'b0;
      head_d              = wrap(32'(head_q) + 1);
    end
    if (push) begin
      mem_d[tail].addr  = WQ_ADDR_MAX_W'(push_addr);
      mem_d[tail].data  = WQ_DATA_MAX_W'(push_data);
      mem_d[tail].valid = 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Queue storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pcm_sched.sv
// PCM request scheduler: queues writes, forwards read hits from the queue,
// and keeps at most one PCM command outstanding.
module pcm_sched
  import pcm_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned WQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          pcm_cmd_valid,
  output logic                          pcm_cmd_write,
  output logic [ADDR_W-1:0]             pcm_addr,
  output logic [DATA_W-1:0]             pcm_wdata,
  input  logic                          pcm_done,
  input  logic [DATA_W-1:0]             pcm_rdata,
  output logic [$clog2(WQ_DEPTH+1)-1:0] wq_count
);

  localparam int unsigned CNT_W = $clog2(WQ_DEPTH + 1);
  localparam int unsigned PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] pcm_addr_q, pcm_addr_d;
  logic [DATA_W-1:0] pcm_wdata_q, pcm_wdata_d;

  logic [CNT_W-1:0]  wq_cnt;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data, hit_data;
  logic              rd_hit, wr_hit;
  logic [PTR_W-1:0]  wr_idx;
  logic              issue_wr, issue_rd, wr_done, rd_done, head_busy;
  logic              wr_ok, rd_ok, wr_acc, rd_acc, push, coal;

  pcm_wq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WQ_DEPTH)
  ) u_wq (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (req_addr),
    .push_data  (req_wdata),
    .coal       (coal),
    .coal_idx   (wr_idx),
    .pop        (wr_done),
    .head_busy  (head_busy),
    .match_addr (req_addr),
    .count      (wq_cnt),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .rd_hit     (rd_hit),
    .rd_data    (hit_data),
    .wr_hit     (wr_hit),
    .wr_idx     (wr_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Issue priority from registered state: full queue, pending read, any write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wq_cnt == CNT_W'(WQ_DEPTH)) state_d = WR_BUSY;
        else if (pend_q)                state_d = RD_BUSY;
        else if (wq_cnt != '0)          state_d = WR_BUSY;
      end
      RD_BUSY: if (pcm_done) state_d = IDLE;
      WR_BUSY: if (pcm_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM decodes; pcm_done outside a busy state is ignored.
  always_comb begin
    issue_wr  = (state_q == IDLE) && (state_d == WR_BUSY);
    issue_rd  = (state_q == IDLE) && (state_d == RD_BUSY);
    wr_done   = (state_q == WR_BUSY) && pcm_done;
    rd_done   = (state_q == RD_BUSY) && pcm_done;
    head_busy = (state_q == WR_BUSY);
  end

  // Request acceptance: registered count only, so a same-cycle pop never
  // frees a slot early.
  always_comb begin
    wr_ok     = wr_hit || (wq_cnt < CNT_W'(WQ_DEPTH));
    rd_ok     = !pend_q && (state_q != RD_BUSY);
    req_ready = req_write ? wr_ok : rd_ok;
    wr_acc    = req_valid && req_ready && req_write;
    rd_acc    = req_valid && req_ready && !req_write;
    push      = wr_acc && !wr_hit;
    coal      = wr_acc && wr_hit;
  end

  // Pending read, response and command register next values.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (rd_acc && !rd_hit) begin
      pend_d      = 1'b1;
      pend_addr_d = req_addr;
    end else if (rd_done) begin
      pend_d = 1'b0;
    end

    rsp_valid_d = (rd_acc && rd_hit) || rd_done;
    rsp_data_d  = rsp_data_q;
    if (rd_acc && rd_hit) rsp_data_d = hit_data;
    else if (rd_done)     rsp_data_d = pcm_rdata;

    cmd_valid_d = issue_wr || issue_rd;
    cmd_write_d = cmd_write_q;
    pcm_addr_d  = pcm_addr_q;
    pcm_wdata_d = pcm_wdata_q;
    if (issue_wr) begin
      cmd_write_d = 1'b1;
      pcm_addr_d  = head_addr;
      pcm_wdata_d = head_data;
    end else if (issue_rd) begin
      cmd_write_d = 1'b0;
      pcm_addr_d  = pend_addr_q;
      pcm_wdata_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      pcm_addr_q  <= '0;
      pcm_wdata_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      pcm_addr_q  <= pcm_addr_d;
      pcm_wdata_q <= pcm_wdata_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign pcm_cmd_valid = cmd_valid_q;
  assign pcm_cmd_write = cmd_write_q;
  assign pcm_addr      = pcm_addr_q;
  assign pcm_wdata     = pcm_wdata_q;
  assign wq_count      = wq_cnt;

endmodule

// File: tb/tb_pcm_sched.sv
// Bench for pcm_sched: directed scenarios, then randomized traffic checked
// against a transaction-level queue/memory model.
module tb_pcm_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_ready;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        pcm_cmd_valid, pcm_cmd_write;
  logic [19:0] pcm_addr;
  logic [15:0] pcm_wdata;
  logic        pcm_done;
  logic [15:0] pcm_rdata;
  logic [2:0]  wq_count;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  pcm_sched #(.ADDR_W(20), .DATA_W(16), .WQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .pcm_cmd_valid(pcm_cmd_valid), .pcm_cmd_write(pcm_cmd_write),
    .pcm_addr(pcm_addr), .pcm_wdata(pcm_wdata),
    .pcm_done(pcm_done), .pcm_rdata(pcm_rdata), .wq_count(wq_count)
  );

  always #5 clk = ~clk;

  // Reference model: queued writes in order, PCM memory, pending read.
  typedef struct { logic [19:0] a; logic [15:0] d; } went_t;
  went_t       wq_m[$];
  logic [15:0] mem_m [logic [19:0]];
  bit          pend_v, infl_wr, infl_rd, outst, exp_rsp_v;
  logic [19:0] pend_a;
  logic [15:0] exp_rsp_d;
  int          lat;
  logic [19:0] addr_tbl [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic w, input logic [19:0] a, input logic [15:0] d);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
  endtask

  task automatic wait_cmd(input string tag);
    int n;
    n = 0;
    while (!pcm_cmd_valid && n < 20) begin tick(); n++; end
    chk({tag, "_issue"}, pcm_cmd_valid, 1);
  endtask

  task automatic complete_write(input string tag, input logic [19:0] a, input logic [15:0] d);
    wait_cmd(tag);
    chk({tag, "_is_wr"}, pcm_cmd_write, 1);
    chk({tag, "_addr"}, pcm_addr, a);
    chk({tag, "_data"}, pcm_wdata, d);
    pcm_done = 1'b1;
    tick();
    pcm_done = 1'b0;
  endtask

  initial begin
    bit          hit_w, rd_h, exp_ready;
    int          hit_i;
    logic [15:0] rd_d;

    addr_tbl[0] = 20'h00010; addr_tbl[1] = 20'h00011; addr_tbl[2] = 20'h00123;
    addr_tbl[3] = 20'h0ABCD; addr_tbl[4] = 20'hFFFFF; addr_tbl[5] = 20'h00000;
    reset = 1'b1; pcm_done = 1'b0; pcm_rdata = '0;
    drv(0, 0, '0, '0);
    repeat (3) tick();

    // Reset values and readiness right after release
    reset = 1'b0;
    drv(0, 1, '0, '0);
    #1;
    chk("rst_ready_wr", req_ready, 1);
    req_write = 1'b0; #1;
    chk("rst_ready_rd", req_ready, 1);
    chk("rst_wq_count", wq_count, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cmd_valid", pcm_cmd_valid, 0);
    chk("rst_cmd_write", pcm_cmd_write, 0);
    chk("rst_pcm_addr", pcm_addr, 0);
    chk("rst_pcm_wdata", pcm_wdata, 0);

    // Read forwarded from the queue
    tick(); drv(1, 1, 20'h00010, 16'hAAAA); #1; chk("a_wr_ready", req_ready, 1);
    tick(); drv(1, 0, 20'h00010, 16'h0); #1; chk("a_rd_ready", req_ready, 1);
    tick(); drv(0, 0, '0, '0);
    chk("a_rsp_valid", rsp_valid, 1);
    chk("a_rsp_data", rsp_data, 16'hAAAA);
    chk("a_cmd_is_wr", pcm_cmd_write, 1);
    chk("a_cmd_addr", pcm_addr, 20'h00010);
    pcm_done = 1'b1;
    tick(); pcm_done = 1'b0;
    chk("a_rsp_single", rsp_valid, 0);
    chk("a_count_drained", wq_count, 0);

    // Coalescing of same-address writes, including into the issuing head
    tick(); drv(1, 1, 20'h00001, 16'h1111);
    tick(); drv(1, 1, 20'h00001, 16'h2222); #1; chk("b_coal_ready", req_ready, 1);
    tick(); drv(0, 0, '0, '0);
    chk("b_count", wq_count, 1);
    chk("b_cmd_valid", pcm_cmd_valid, 1);
    chk("b_wdata", pcm_wdata, 16'h2222);
    pcm_done = 1'b1;
    tick(); pcm_done = 1'b0;
    chk("b_count_after", wq_count, 0);

    // Full queue with the PCM stalled
    tick(); drv(1, 1, 20'h00100, 16'h0100);
    tick(); drv(1, 1, 20'h00200, 16'h0200);
    tick(); drv(1, 1, 20'h00300, 16'h0300);
    tick(); drv(1, 1, 20'h00400, 16'h0400); #1; chk("c_4th_ready", req_ready, 1);
    tick(); drv(1, 1, 20'h00500, 16'h0500); #1; chk("c_5th_ready", req_ready, 0);
    drv(1, 1, 20'h00100, 16'h0101); #1; chk("c_head_ready", req_ready, 0);
    drv(1, 1, 20'h00300, 16'h3333); #1; chk("c_coal_ready", req_ready, 1);
    tick(); drv(0, 0, '0, '0);
    chk("c_count_full", wq_count, 4);
    chk("c_head_addr", pcm_addr, 20'h00100);
    pcm_done = 1'b1;
    tick(); pcm_done = 1'b0;
    chk("c_count_pop", wq_count, 3);
    complete_write("c_b", 20'h00200, 16'h0200);
    complete_write("c_c", 20'h00300, 16'h3333);
    complete_write("c_d", 20'h00400, 16'h0400);

    // Pending read miss takes priority over a non-full queue
    tick(); drv(1, 1, 20'h00700, 16'h7777);
    tick(); drv(1, 1, 20'h00800, 16'h8888);
    tick(); drv(1, 0, 20'h00123, 16'h0); #1; chk("d_rd_ready", req_ready, 1);
    chk("d_w1_addr", pcm_addr, 20'h00700);
    tick(); drv(0, 0, '0, '0); #1; chk("d_pend_block", req_ready, 0);
    pcm_done = 1'b1;
    tick(); pcm_done = 1'b0;
    wait_cmd("d_rd");
    chk("d_rd_is_rd", pcm_cmd_write, 0);
    chk("d_rd_addr", pcm_addr, 20'h00123);
    chk("d_busy_block", req_ready, 0);
    chk("d_no_early_rsp", rsp_valid, 0);
    pcm_done = 1'b1; pcm_rdata = 16'h5A5A;
    tick(); pcm_done = 1'b0; pcm_rdata = '0;
    chk("d_rsp_valid", rsp_valid, 1);
    chk("d_rsp_data", rsp_data, 16'h5A5A);
    complete_write("d_w2", 20'h00800, 16'h8888);

    // Reset during WR_BUSY abandons the command
    tick(); drv(1, 1, 20'h00900, 16'h9999);
    tick(); drv(0, 0, '0, '0);
    tick(); chk("e_issued", pcm_cmd_valid, 1);
    reset = 1'b1; #1;
    chk("e_rst_addr", pcm_addr, 0);
    chk("e_rst_wdata", pcm_wdata, 0);
    chk("e_rst_write", pcm_cmd_write, 0);
    chk("e_rst_count", wq_count, 0);
    chk("e_rst_rsp_data", rsp_data, 0);
    tick(); reset = 1'b0; pcm_done = 1'b1;
    tick(); pcm_done = 1'b0;
    chk("e_no_rsp", rsp_valid, 0);
    chk("e_count", wq_count, 0);
    chk("e_no_cmd", pcm_cmd_valid, 0);
    tick(); chk("e_still_idle", pcm_cmd_valid, 0);

    // Randomized traffic against the model
    pend_v = 0; infl_wr = 0; infl_rd = 0; outst = 0; exp_rsp_v = 0;
    exp_rsp_d = '0; pend_a = '0; lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      chk("r_rsp_valid", rsp_valid, exp_rsp_v);
      if (exp_rsp_v) chk("r_rsp_data", rsp_data, exp_rsp_d);
      chk("r_wq_count", wq_count, wq_m.size());
      exp_rsp_v = 0;
      if (pcm_cmd_valid) begin
        chk("r_one_outstanding", outst, 0);
        if (pcm_cmd_write) begin
          chk("r_wr_nonempty", wq_m.size() != 0, 1);
          if (wq_m.size() != 0) begin
            chk("r_wr_addr", pcm_addr, wq_m[0].a);
            chk("r_wr_data", pcm_wdata, wq_m[0].d);
          end
          infl_wr = 1;
        end else begin
          chk("r_rd_pending", pend_v, 1);
          chk("r_rd_addr", pcm_addr, pend_a);
          infl_rd = 1;
        end
        outst = 1;
        lat = $urandom_range(0, 3);
      end

      pcm_done = 1'b0;
      if (outst) begin
        if (lat == 0) pcm_done = 1'b1;
        else lat--;
      end else if ($urandom_range(0, 15) == 0) begin
        pcm_done = 1'b1;
      end
      if (outst && infl_rd && pcm_done && mem_m.exists(pend_a)) pcm_rdata = mem_m[pend_a];
      else pcm_rdata = 16'($urandom);
      drv($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
          addr_tbl[$urandom_range(0, 5)], 16'($urandom));
      #1;

      hit_w = 0; hit_i = 0; rd_h = 0; rd_d = '0;
      for (int i = 0; i < wq_m.size(); i++) begin
        if (wq_m[i].a == req_addr) begin
          rd_h = 1; rd_d = wq_m[i].d;
          if (!(i == 0 && infl_wr)) begin hit_w = 1; hit_i = i; end
        end
      end
      exp_ready = req_write ? (hit_w || wq_m.size() < 4) : !pend_v;
      chk("r_req_ready", req_ready, exp_ready);

      if (req_valid && exp_ready) begin
        if (req_write) begin
          if (hit_w) wq_m[hit_i].d = req_wdata;
          else wq_m.push_back('{a: req_addr, d: req_wdata});
        end else if (rd_h) begin
          exp_rsp_v = 1; exp_rsp_d = rd_d;
        end else begin
          pend_v = 1; pend_a = req_addr;
        end
      end
      if (pcm_done && outst) begin
        if (infl_wr) begin
          mem_m[wq_m[0].a] = wq_m[0].d;
          void'(wq_m.pop_front());
        end else begin
          exp_rsp_v = 1; exp_rsp_d = pcm_rdata; pend_v = 0;
        end
        outst = 0; infl_wr = 0; infl_rd = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
